board_display_scanner: RTL and testbench

- Reads the board state that the main FSM publishes when it enters its display state.
- Captures the 25-bit mine and cleared vectors, then walks the 5x5 grid one cell per accepted beat.
- Emits a 4-bit symbol code per cell on a valid/ready stream toward the LED/UART front end.
- Returns a one-cycle done pulse so the main FSM can leave display and wait for the next move.

---
 rtl/minesweeper_pkg.sv | 44 ++++
 rtl/neighbour_counter.sv | 31 +++
 rtl/board_display_scanner.sv | 138 +++++++++++++
 tb/tb_board_display_scanner.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared board constants, symbol codes and scanner state type for the
// minesweeper blocks (scanner, decode, ALU).
package minesweeper_pkg;

    localparam int unsigned ROWS  = 5;
    localparam int unsigned COLS  = 5;
    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned IDX_W = 5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);

    localparam logic [3:0] CODE_HIDDEN = 4'd9;
    localparam logic [3:0] CODE_MINE   = 4'd10;
    localparam logic [3:0] CODE_BOOM   = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    // Symbol for one cell: exploded mine, revealed mine, hidden, or count.
    function automatic logic [3:0] cell_code(
        input logic       mine,
        input logic       cleared,
        input logic       ended,
        input logic [3:0] count
    );
        if (mine && cleared) begin
            return CODE_BOOM;
        end else if (mine && ended) begin
            return CODE_MINE;
        end else if (!cleared) begin
            return CODE_HIDDEN;
        end
        return count;
    endfunction

    // True when the cell sits in the rightmost column.
    function automatic logic is_row_end(input logic [IDX_W-1:0] idx);
        return (32'(idx) % COLS) == (COLS - 1);
    endfunction

endpackage

// File: rtl/neighbour_counter.sv
// Combinational count of mines among the in-bounds 8-neighbourhood of a cell.
module neighbour_counter
    import minesweeper_pkg::*;
(
    input  logic [CELLS-1:0] mines,
    input  logic [IDX_W-1:0] index,
    output logic [3:0]       count
);

    int row;
    int col;
    int nr;
    int nc;

    // Walk the 3x3 window around the cell, skipping the centre and off-board cells.
    always_comb begin
        count = '0;
        row   = int'(index) / int'(COLS);
        col   = int'(index) % int'(COLS);
        nr    = 0;
        nc    = 0;
        for (int unsigned k = 0; k < 9; k++) begin
            nr = row + int'(k / 3) - 1;
            nc = col + int'(k % 3) - 1;
            if (k != 4 && nr >= 0 && nr < int'(ROWS) && nc >= 0 && nc < int'(COLS)) begin
                count = count + 4'(mines[nr * int'(COLS) + nc]);
            end
        end
    end

endmodule

// File: rtl/board_display_scanner.sv
// Captures the published board and streams one symbol code per cell over
// a valid/ready interface, then pulses done for the main FSM.
module board_display_scanner
    import minesweeper_pkg::*;
(
    input  logic             in_clka,
    input  logic             in_restart,
    input  logic             in_display,
    input  logic [CELLS-1:0] in_mines,
    input  logic [CELLS-1:0] in_cleared,
    input  logic             in_gameover,
    input  logic             in_win,
    input  logic             in_ready,
    output logic             out_cell_valid,
    output logic [IDX_W-1:0] out_cell_index,
    output logic [3:0]       out_cell_code,
    output logic             out_row_end,
    output logic             out_busy,
    output logic             out_display_done
);

    scan_state_t      state;
    logic [CELLS-1:0] mines_q;
    logic [CELLS-1:0] cleared_q;
    logic             gameover_q;
    logic             win_q;

    logic             valid_q;
    logic [IDX_W-1:0] index_q;
    logic [3:0]       code_q;
    logic             row_end_q;
    logic             busy_q;
    logic             done_q;

    logic [CELLS-1:0] src_mines;
    logic [CELLS-1:0] src_cleared;
    logic             src_ended;
    logic [IDX_W-1:0] next_idx;
    logic [3:0]       nb_count;
    logic [3:0]       next_code;
    logic             next_row_end;

    // The first beat is registered on the capture edge itself, so in IDLE the
    // code is computed straight from the live inputs; afterwards it comes from
    // the captured board for the index that follows the presented one.
    always_comb begin
        if (state == IDLE) begin
            src_mines   = in_mines;
            src_cleared = in_cleared;
            src_ended   = in_gameover | in_win;
            next_idx    = '0;
        end else begin
            src_mines   = mines_q;
            src_cleared = cleared_q;
            src_ended   = gameover_q | win_q;
            next_idx    = (index_q == LAST_IDX) ? index_q : index_q + 1'b1;
        end
    end

    neighbour_counter u_neighbour_counter (
        .mines (src_mines),
        .index (next_idx),
        .count (nb_count)
    );

    // Symbol and row marker for the beat that will be presented next.
    always_comb begin
        next_code    = cell_code(src_mines[next_idx], src_cleared[next_idx], src_ended, nb_count);
        next_row_end = is_row_end(next_idx);
    end

    // Scanner FSM: capture in IDLE, stream beats in SCAN, pulse done in DONE.
    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            state      <= IDLE;
            mines_q    <= '0;
            cleared_q  <= '0;
            gameover_q <= 1'b0;
            win_q      <= 1'b0;
            valid_q    <= 1'b0;
            index_q    <= '0;
            code_q     <= '0;
            row_end_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (in_display) begin
                        mines_q    <= in_mines;
                        cleared_q  <= in_cleared;
                        gameover_q <= in_gameover;
                        win_q      <= in_win;
                        index_q    <= next_idx;
                        code_q     <= next_code;
                        row_end_q  <= next_row_end;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (in_ready) begin
                        if (index_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            index_q   <= next_idx;
                            code_q    <= next_code;
                            row_end_q <= next_row_end;
                        end
                    end
                end
                DONE: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    index_q   <= '0;
                    code_q    <= '0;
                    row_end_q <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_cell_valid   = valid_q;
    assign out_cell_index   = index_q;
    assign out_cell_code    = code_q;
    assign out_row_end      = row_end_q;
    assign out_busy         = busy_q;
    assign out_display_done = done_q;

endmodule

// File: tb/tb_board_display_scanner.sv
// Self-checking bench for board_display_scanner against a grid-level model.
module tb_board_display_scanner;

    logic        clk;
    logic        rst;
    logic        in_display;
    logic [24:0] in_mines;
    logic [24:0] in_cleared;
    logic        in_gameover;
    logic        in_win;
    logic        in_ready;
    logic        out_cell_valid;
    logic [4:0]  out_cell_index;
    logic [3:0]  out_cell_code;
    logic        out_row_end;
    logic        out_busy;
    logic        out_display_done;

    int checks;
    int failures;

    // captured beats from the most recent scan
    int         nb;
    int         b_idx [64];
    logic [3:0] b_code[64];
    logic       b_re  [64];
    int         b_cyc [64];
    int         done_cyc;
    int         done_cnt;
    int         busy_first;
    int         busy_last;
    int         busy_cnt;
    bit         timed_out;
    int         stalls;
    int         stall_idx [8];
    logic [3:0] stall_code[8];

    board_display_scanner dut (
        .in_clka          (clk),
        .in_restart       (rst),
        .in_display       (in_display),
        .in_mines         (in_mines),
        .in_cleared       (in_cleared),
        .in_gameover      (in_gameover),
        .in_win           (in_win),
        .in_ready         (in_ready),
        .out_cell_valid   (out_cell_valid),
        .out_cell_index   (out_cell_index),
        .out_cell_code    (out_cell_code),
        .out_row_end      (out_row_end),
        .out_busy         (out_busy),
        .out_display_done (out_display_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference symbol: neighbours are any other cell within one row and one column.
    function automatic logic [3:0] model_code(input logic [24:0] m, input logic [24:0] c,
                                              input logic ended, input int idx);
        int r;
        int col;
        int n;
        int dr;
        int dc;
        r   = idx / 5;
        col = idx % 5;
        n   = 0;
        if (m[idx] && c[idx]) return 4'd11;
        if (m[idx] && ended) return 4'd10;
        if (!c[idx]) return 4'd9;
        for (int j = 0; j < 25; j++) begin
            dr = j / 5 - r;
            dc = j % 5 - col;
            if (j != idx && dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1 && m[j]) n++;
        end
        return 4'(n);
    endfunction

    task automatic start_display(input logic [24:0] m, input logic [24:0] c,
                                 input logic go, input logic w);
        @(negedge clk);
        in_mines    = m;
        in_cleared  = c;
        in_gameover = go;
        in_win      = w;
        in_display  = 1'b1;
        in_ready    = 1'b1;
        @(posedge clk);
        #1;
        in_display  = 1'b0;
        in_mines    = 25'($urandom);
        in_cleared  = 25'($urandom);
        in_gameover = 1'($urandom);
        in_win      = 1'($urandom);
    endtask

    // Drives ready (and optional stall / re-trigger) and records what the DUT presents.
    task automatic collect(input int stall_beat, input int stall_len, input int retrig_beat,
                           input int ready_pct, input bit stop_at_done);
        bit rdy;
        bit retrig_done;
        nb = 0; done_cyc = -1; done_cnt = 0;
        busy_first = -1; busy_last = -1; busy_cnt = 0;
        stalls = 0; timed_out = 1'b1; retrig_done = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            in_display = 1'b0;
            if (out_busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
                busy_cnt++;
            end
            if (out_display_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            rdy = (int'($urandom_range(99)) < ready_pct);
            if (out_cell_valid && int'(out_cell_index) == stall_beat && stalls < stall_len) begin
                rdy = 1'b0;
                stall_idx[stalls]  = int'(out_cell_index);
                stall_code[stalls] = out_cell_code;
                stalls++;
            end
            if (out_cell_valid && int'(out_cell_index) == retrig_beat && !retrig_done) begin
                in_display  = 1'b1;
                in_mines    = 25'($urandom);
                in_cleared  = 25'($urandom);
                in_gameover = 1'($urandom);
                retrig_done = 1'b1;
            end
            in_ready = rdy;
            if (out_cell_valid && rdy && nb < 64) begin
                b_idx[nb]  = int'(out_cell_index);
                b_code[nb] = out_cell_code;
                b_re[nb]   = out_row_end;
                b_cyc[nb]  = cyc;
                nb++;
            end
            if (done_cyc >= 0 && (stop_at_done || cyc >= done_cyc + 3)) begin
                timed_out = 1'b0;
                break;
            end
        end
        in_ready = 1'b1;
        if (timed_out) begin
            checks++; failures++;
            $display("FAIL scan_timeout got=no_done exp=done_within_300_cycles");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        checks++;
        if ({out_cell_valid, out_cell_index, out_cell_code, out_row_end, out_busy, out_display_done} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=v%b i%0d c%0d re%b b%b d%b exp=all_zero",
                     out_cell_valid, out_cell_index, out_cell_code, out_row_end, out_busy, out_display_done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_busy !== 1'b0 || out_cell_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got=b%b v%b exp=b0 v0", out_busy, out_cell_valid);
        end
    endtask

    task automatic test_basic;
        logic [24:0] m;
        logic [24:0] c;
        m = 25'h0001041;
        c = 25'h1000002;
        start_display(m, c, 1'b0, 1'b0);
        collect(-1, 0, -1, 100, 1'b0);
        checks++;
        if (nb !== 25) begin failures++; $display("FAIL basic_beats got=%0d exp=25", nb); end
        for (int k = 0; k < nb && k < 25; k++) begin
            checks++;
            if (b_idx[k] !== k || b_code[k] !== model_code(m, c, 1'b0, k) ||
                b_re[k] !== (k % 5 == 4) || b_cyc[k] !== k + 1) begin
                failures++;
                $display("FAIL basic_beat%0d got=i%0d c%0d re%b cyc%0d exp=i%0d c%0d re%b cyc%0d", k,
                         b_idx[k], b_code[k], b_re[k], b_cyc[k], k, model_code(m, c, 1'b0, k), (k % 5 == 4), k + 1);
            end
        end
        checks++;
        if (b_code[1] !== 4'd2 || b_code[24] !== 4'd0 || b_code[0] !== 4'd9 ||
            b_code[6] !== 4'd9 || b_code[12] !== 4'd9) begin
            failures++;
            $display("FAIL basic_fixed got=%0d,%0d,%0d,%0d,%0d exp=2,0,9,9,9",
                     b_code[1], b_code[24], b_code[0], b_code[6], b_code[12]);
        end
        checks++;
        if (done_cyc !== 26 || done_cnt !== 1) begin
            failures++;
            $display("FAIL basic_done got=cyc%0d cnt%0d exp=cyc26 cnt1", done_cyc, done_cnt);
        end
        checks++;
        if (busy_first !== 1 || busy_last !== 26 || busy_cnt !== 26) begin
            failures++;
            $display("FAIL basic_busy got=%0d..%0d n%0d exp=1..26 n26", busy_first, busy_last, busy_cnt);
        end
    endtask

    task automatic test_wrap;
        start_display(25'h0000010, 25'h0000028, 1'b0, 1'b0);
        collect(-1, 0, -1, 100, 1'b0);
        checks++;
        if (nb !== 25 || b_code[5] !== 4'd0 || b_code[3] !== 4'd1) begin
            failures++;
            $display("FAIL wrap got=n%0d c5=%0d c3=%0d exp=n25 c5=0 c3=1", nb, b_code[5], b_code[3]);
        end
    endtask

    task automatic test_gameover;
        logic [24:0] m;
        logic [24:0] c;
        m = 25'h0001041;
        c = 25'h0000040;
        start_display(m, c, 1'b1, 1'b0);
        collect(-1, 0, -1, 100, 1'b0);
        checks++;
        if (nb !== 25 || b_code[6] !== 4'd11 || b_code[0] !== 4'd10 || b_code[12] !== 4'd10 || b_code[7] !== 4'd9) begin
            failures++;
            $display("FAIL gameover got=n%0d c6=%0d c0=%0d c12=%0d c7=%0d exp=n25 11 10 10 9",
                     nb, b_code[6], b_code[0], b_code[12], b_code[7]);
        end
        for (int k = 0; k < nb && k < 25; k++) begin
            checks++;
            if (b_code[k] !== model_code(m, c, 1'b1, k)) begin
                failures++;
                $display("FAIL gameover_beat%0d got=%0d exp=%0d", k, b_code[k], model_code(m, c, 1'b1, k));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [24:0] m;
        logic [24:0] c;
        m = 25'($urandom);
        c = 25'($urandom);
        start_display(m, c, 1'b0, 1'b1);
        collect(10, 3, -1, 100, 1'b0);
        checks++;
        if (stalls !== 3) begin failures++; $display("FAIL bp_stalls got=%0d exp=3", stalls); end
        for (int s = 0; s < stalls && s < 8; s++) begin
            checks++;
            if (stall_idx[s] !== 10 || stall_code[s] !== model_code(m, c, 1'b1, 10)) begin
                failures++;
                $display("FAIL bp_stable%0d got=i%0d c%0d exp=i10 c%0d", s, stall_idx[s], stall_code[s],
                         model_code(m, c, 1'b1, 10));
            end
        end
        checks++;
        if (nb !== 25 || b_cyc[10] !== 14 || b_cyc[11] !== 15 || b_idx[11] !== 11) begin
            failures++;
            $display("FAIL bp_timing got=n%0d acc10@%0d acc11@%0d idx%0d exp=n25 14 15 11",
                     nb, b_cyc[10], b_cyc[11], b_idx[11]);
        end
        checks++;
        if (done_cyc !== 29 || done_cnt !== 1) begin
            failures++;
            $display("FAIL bp_done got=cyc%0d cnt%0d exp=cyc29 cnt1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_retrigger;
        logic [24:0] m;
        logic [24:0] c;
        m = 25'($urandom);
        c = 25'($urandom);
        start_display(m, c, 1'b0, 1'b0);
        collect(-1, 0, 5, 100, 1'b0);
        checks++;
        if (nb !== 25 || done_cyc !== 26 || done_cnt !== 1) begin
            failures++;
            $display("FAIL retrig_shape got=n%0d cyc%0d cnt%0d exp=n25 cyc26 cnt1", nb, done_cyc, done_cnt);
        end
        for (int k = 0; k < nb && k < 25; k++) begin
            checks++;
            if (b_idx[k] !== k || b_code[k] !== model_code(m, c, 1'b0, k)) begin
                failures++;
                $display("FAIL retrig_beat%0d got=i%0d c%0d exp=i%0d c%0d", k, b_idx[k], b_code[k],
                         k, model_code(m, c, 1'b0, k));
            end
        end
        checks++;
        if (out_busy !== 1'b0 || out_cell_valid !== 1'b0) begin
            failures++;
            $display("FAIL retrig_idle got=b%b v%b exp=b0 v0", out_busy, out_cell_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [24:0] m;
        logic [24:0] c;
        start_display(25'($urandom), 25'($urandom), 1'b0, 1'b0);
        collect(-1, 0, -1, 100, 1'b1);
        checks++;
        if (done_cyc !== 26) begin failures++; $display("FAIL b2b_first_done got=%0d exp=26", done_cyc); end
        m = 25'($urandom);
        c = 25'($urandom);
        start_display(m, c, 1'b1, 1'b0);
        collect(-1, 0, -1, 100, 1'b0);
        checks++;
        if (nb !== 25 || done_cyc !== 26 || b_idx[0] !== 0) begin
            failures++;
            $display("FAIL b2b_second got=n%0d cyc%0d first%0d exp=n25 cyc26 first0", nb, done_cyc, b_idx[0]);
        end
        for (int k = 0; k < nb && k < 25; k++) begin
            checks++;
            if (b_code[k] !== model_code(m, c, 1'b1, k)) begin
                failures++;
                $display("FAIL b2b_beat%0d got=%0d exp=%0d", k, b_code[k], model_code(m, c, 1'b1, k));
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        logic [24:0] m;
        logic [24:0] c;
        bit          hit;
        hit = 1'b0;
        start_display(25'($urandom), 25'($urandom), 1'b0, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            in_ready = 1'b1;
            if (out_cell_valid && out_cell_index == 5'd7) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL midrst_reach got=no_beat7 exp=beat7"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_cell_valid, out_busy, out_display_done, out_cell_index} !== 8'd0) begin
            failures++;
            $display("FAIL midrst_async got=v%b b%b d%b i%0d exp=all_zero",
                     out_cell_valid, out_busy, out_display_done, out_cell_index);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_busy !== 1'b0 || out_cell_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle got=b%b v%b exp=b0 v0", out_busy, out_cell_valid);
        end
        m = 25'($urandom);
        c = 25'($urandom);
        start_display(m, c, 1'b0, 1'b0);
        collect(-1, 0, -1, 100, 1'b0);
        checks++;
        if (nb !== 25 || b_idx[0] !== 0 || b_code[0] !== model_code(m, c, 1'b0, 0)) begin
            failures++;
            $display("FAIL midrst_restart got=n%0d i%0d c%0d exp=n25 i0 c%0d", nb, b_idx[0], b_code[0],
                     model_code(m, c, 1'b0, 0));
        end
    endtask

    task automatic test_random;
        logic [24:0] m;
        logic [24:0] c;
        logic        go;
        logic        w;
        for (int t = 0; t < 5; t++) begin
            m  = 25'($urandom) & 25'($urandom);
            c  = 25'($urandom);
            go = 1'($urandom);
            w  = 1'($urandom);
            start_display(m, c, go, w);
            collect(-1, 0, -1, 60, 1'b0);
            checks++;
            if (nb !== 25 || done_cnt !== 1) begin
                failures++;
                $display("FAIL rand%0d_shape got=n%0d done%0d exp=n25 done1", t, nb, done_cnt);
            end
            for (int k = 0; k < nb && k < 25; k++) begin
                checks++;
                if (b_idx[k] !== k || b_code[k] !== model_code(m, c, go | w, k) || b_re[k] !== (k % 5 == 4)) begin
                    failures++;
                    $display("FAIL rand%0d_beat%0d got=i%0d c%0d re%b exp=i%0d c%0d re%b", t, k,
                             b_idx[k], b_code[k], b_re[k], k, model_code(m, c, go | w, k), (k % 5 == 4));
                end
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        in_display  = 1'b0;
        in_mines    = '0;
        in_cleared  = '0;
        in_gameover = 1'b0;
        in_win      = 1'b0;
        in_ready    = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_gameover();
        test_backpressure();
        test_retrigger();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
